// File: rtl/m_seq_pkg.sv
// Shared constants for the m-sequence generator: maximal-length tap masks
// and the period of a maximal sequence for a given register width.
package m_seq_pkg;

  localparam int SEQ_WIDTH_MIN = 3;
  localparam int SEQ_WIDTH_MAX = 16;

  // Period of a maximal-length sequence: every nonzero state visited once.
  function automatic int seq_period(input int width);
    return (1 << width) - 1;
  endfunction

  // Feedback masks giving maximal length with a left-shifting register whose
  // feedback bit enters at bit 0. Bit WIDTH-1 is always set.
  function automatic logic [15:0] max_len_taps(input int width);
    case (width)
      3:       return 16'h0006;
      4:       return 16'h000C;
      5:       return 16'h0014;
      6:       return 16'h0030;
      7:       return 16'h0060;
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0829;
      13:      return 16'h100D;
      14:      return 16'h2015;
      15:      return 16'h6000;
      16:      return 16'hD008;
      default: return 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/m_seq_period_chk.sv
// Period monitor: counts steps since the last load/reset and flags any step
// where returning to the start value disagrees with the expected period.
module m_seq_period_chk
  import m_seq_pkg::*;
#(
  parameter int               WIDTH     = 3,
  parameter logic [WIDTH-1:0] SEED_INIT = 3'b101
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] next_state,
  output logic             sync,
  output logic             period_err
);

  localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(seq_period(WIDTH) - 1);

  logic [WIDTH-1:0] start_q;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_nxt;
  logic             mismatch;

  assign cnt_nxt  = (cnt_q == CNT_LAST) ? '0 : cnt_q + WIDTH'(1);
  assign mismatch = (next_state == start_q) != (cnt_nxt == '0);
  assign sync     = (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      start_q    <= SEED_INIT;
      cnt_q      <= '0;
      period_err <= 1'b0;
    end else if (load) begin
      start_q    <= load_val;
      cnt_q      <= '0;
      period_err <= 1'b0;
    end else if (step) begin
      cnt_q <= cnt_nxt;
      if (mismatch) period_err <= 1'b1;
    end
  end

endmodule

// File: rtl/m_seq_gen.sv
// Fibonacci-style LFSR m-sequence generator with seed load, zero-seed
// substitution and a sticky period-violation monitor.
module m_seq_gen
  import m_seq_pkg::*;
#(
  parameter int               WIDTH     = 3,
  parameter logic [WIDTH-1:0] TAPS      = 3'b101,
  parameter logic [WIDTH-1:0] SEED_INIT = 3'b101
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  output logic             m_out,
  output logic [WIDTH-1:0] state,
  output logic             sync,
  output logic             zero_fix,
  output logic             period_err
);

  if (WIDTH < SEQ_WIDTH_MIN || WIDTH > SEQ_WIDTH_MAX) begin : g_bad_width
    $error("m_seq_gen: WIDTH must be in 3..16");
  end
  if (SEED_INIT == '0) begin : g_bad_seed
    $error("m_seq_gen: SEED_INIT must be nonzero");
  end
  if (!TAPS[WIDTH-1]) begin : g_bad_taps
    $error("m_seq_gen: TAPS must include bit WIDTH-1");
  end

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_nxt;
  logic [WIDTH-1:0] load_val;
  logic             fb;
  logic             seed_zero;
  logic             step;
  logic             zero_fix_q;

  assign seed_zero = (seed == '0);
  // A zero seed would lock the register, so it is replaced by SEED_INIT.
  assign load_val  = seed_zero ? SEED_INIT : seed;
  assign fb        = ^(state_q & TAPS);
  assign state_nxt = {state_q[WIDTH-2:0], fb};
  assign step      = en & ~load;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SEED_INIT;
      zero_fix_q <= 1'b0;
    end else begin
      zero_fix_q <= load & seed_zero;
      if (load)     state_q <= load_val;
      else if (en)  state_q <= state_nxt;
    end
  end

  assign state    = state_q;
  assign m_out    = state_q[WIDTH-1];
  assign zero_fix = zero_fix_q;

  m_seq_period_chk #(
    .WIDTH     (WIDTH),
    .SEED_INIT (SEED_INIT)
  ) u_period_chk (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .step       (step),
    .load_val   (load_val),
    .next_state (state_nxt),
    .sync       (sync),
    .period_err (period_err)
  );

endmodule

// File: tb/tb_m_seq_gen.sv
// Self-checking bench: three generator configurations driven by shared
// controls, compared every cycle against a step-count based reference model.
module tb_m_seq_gen;

  logic       clk = 1'b0;
  logic       rst, en, load;
  logic [2:0] seed3;
  logic [7:0] seed8;

  logic       mo0, sy0, zf0, pe0;
  logic [2:0] st0;
  logic       mo1, sy1, zf1, pe1;
  logic [2:0] st1;
  logic       mo2, sy2, zf2, pe2;
  logic [7:0] st2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  m_seq_gen d0 (
    .clk(clk), .rst(rst), .en(en), .load(load), .seed(seed3),
    .m_out(mo0), .state(st0), .sync(sy0), .zero_fix(zf0), .period_err(pe0)
  );

  m_seq_gen #(.WIDTH(3), .TAPS(3'b111), .SEED_INIT(3'b101)) d1 (
    .clk(clk), .rst(rst), .en(en), .load(load), .seed(seed3),
    .m_out(mo1), .state(st1), .sync(sy1), .zero_fix(zf1), .period_err(pe1)
  );

  m_seq_gen #(.WIDTH(8), .TAPS(8'hB8), .SEED_INIT(8'h01)) d2 (
    .clk(clk), .rst(rst), .en(en), .load(load), .seed(seed8),
    .m_out(mo2), .state(st2), .sync(sy2), .zero_fix(zf2), .period_err(pe2)
  );

  // Reference model, one slot per instance; k counts steps since load/reset.
  int cw[3] = '{3, 3, 8};
  int ct[3] = '{5, 7, 'hB8};
  int cs[3] = '{5, 5, 1};
  int m_st[3], m_start[3], m_k[3];
  bit m_zf[3], m_pe[3];

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int lfsr_next(input int s, input int t, input int w);
    int fb = 0;
    for (int b = 0; b < w; b++)
      if (((s & t) >> b) & 1) fb ^= 1;
    return ((s << 1) | fb) & ((1 << w) - 1);
  endfunction

  task automatic model_update(input bit r, input bit e, input bit l, input int s3, input int s8);
    for (int i = 0; i < 3; i++) begin
      int p, s, nx;
      p = (1 << cw[i]) - 1;
      s = (i == 2) ? s8 : s3;
      if (r) begin
        m_st[i] = cs[i]; m_start[i] = cs[i]; m_k[i] = 0; m_zf[i] = 0; m_pe[i] = 0;
      end else if (l) begin
        m_st[i] = (s == 0) ? cs[i] : s;
        m_start[i] = m_st[i]; m_k[i] = 0; m_zf[i] = (s == 0); m_pe[i] = 0;
      end else begin
        m_zf[i] = 0;
        if (e) begin
          nx = lfsr_next(m_st[i], ct[i], cw[i]);
          if ((nx == m_start[i]) != (((m_k[i] + 1) % p) == 0)) m_pe[i] = 1;
          m_st[i] = nx;
          m_k[i]++;
        end
      end
    end
  endtask

  task automatic compare_all();
    int os[3], om[3], osy[3], ozf[3], ope[3];
    os  = '{int'(st0), int'(st1), int'(st2)};
    om  = '{int'(mo0), int'(mo1), int'(mo2)};
    osy = '{int'(sy0), int'(sy1), int'(sy2)};
    ozf = '{int'(zf0), int'(zf1), int'(zf2)};
    ope = '{int'(pe0), int'(pe1), int'(pe2)};
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("d%0d.state", i), os[i], m_st[i]);
      chk($sformatf("d%0d.m_out", i), om[i], (m_st[i] >> (cw[i] - 1)) & 1);
      chk($sformatf("d%0d.sync", i), osy[i], int'((m_k[i] % ((1 << cw[i]) - 1)) == 0));
      chk($sformatf("d%0d.zero_fix", i), ozf[i], int'(m_zf[i]));
      chk($sformatf("d%0d.period_err", i), ope[i], int'(m_pe[i]));
      if (os[i] == 0) chk($sformatf("d%0d.nonzero", i), os[i], m_st[i] == 0 ? -1 : m_st[i]);
    end
  endtask

  task automatic cycle(input bit r, input bit e, input bit l, input int s3, input int s8);
    @(negedge clk);
    rst = r; en = e; load = l; seed3 = 3'(s3); seed8 = 8'(s8);
    @(posedge clk);
    model_update(r, e, l, s3 & 7, s8 & 255);
    #1;
    compare_all();
  endtask

  int exp_st[8] = '{5, 2, 4, 1, 3, 7, 6, 5};
  int exp_mo[8] = '{1, 0, 1, 0, 0, 1, 1, 1};
  int sync_cnt;

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; seed3 = '0; seed8 = '0;

    // Defaults: reset then a full period of steps.
    cycle(1, 0, 0, 0, 0);
    chk("rst.state", int'(st0), exp_st[0]);
    chk("rst.sync", int'(sy0), 1);
    for (int i = 1; i < 8; i++) begin
      cycle(0, 1, 0, 0, 0);
      chk($sformatf("seq%0d.state", i), int'(st0), exp_st[i]);
      chk($sformatf("seq%0d.m_out", i), int'(mo0), exp_mo[i]);
      chk($sformatf("seq%0d.sync", i), int'(sy0), int'(i == 7));
    end
    chk("seq.period_err", int'(pe0), 0);

    // Zero seed substitution.
    cycle(0, 0, 1, 0, 0);
    chk("zseed.state", int'(st0), 5);
    chk("zseed.zero_fix", int'(zf0), 1);
    chk("zseed.sync", int'(sy0), 1);
    cycle(0, 0, 0, 0, 0);
    chk("zseed.zero_fix_after", int'(zf0), 0);

    // Load beats en.
    cycle(0, 1, 1, 3, 3);
    chk("ldpri.state", int'(st0), 3);
    cycle(0, 1, 0, 0, 0);
    chk("ldpri.step", int'(st0), 7);

    // Short-period taps trip the sticky error.
    cycle(0, 0, 1, 5, 1);
    cycle(0, 1, 0, 0, 0);
    chk("short.s1", int'(st1), 2);
    chk("short.pe1", int'(pe1), 0);
    cycle(0, 1, 0, 0, 0);
    chk("short.s2", int'(st1), 5);
    chk("short.pe2", int'(pe1), 1);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0);
    chk("short.sticky", int'(pe1), 1);
    cycle(0, 0, 1, 5, 1);
    chk("short.cleared", int'(pe1), 0);

    // Width 8: two full periods.
    cycle(1, 0, 0, 0, 0);
    sync_cnt = 0;
    for (int i = 0; i < 510; i++) begin
      cycle(0, 1, 0, 0, 0);
      if (sy2) sync_cnt++;
    end
    chk("w8.sync_count", sync_cnt, 2);
    chk("w8.sync_end", int'(sy2), 1);
    chk("w8.period_err", int'(pe2), 0);

    // Reset mid-sequence with en held.
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    chk("midrst.state", int'(st0), 5);
    chk("midrst.sync", int'(sy0), 1);
    cycle(0, 1, 0, 0, 0);
    chk("midrst.restart", int'(st0), 2);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      bit r, e, l;
      int s3, s8;
      r  = ($urandom_range(0, 49) == 0);
      l  = ($urandom_range(0, 9) == 0);
      e  = ($urandom_range(0, 9) < 7);
      s3 = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 7));
      s8 = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 255));
      cycle(r, e, l, s3, s8);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
